seg7_reader: RTL

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg7_reader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment patterns shared with the segment driver, plus the reader FSM states.
// Patterns are active-high with bit 0 = segment a through bit 6 = segment g.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    localparam logic [SEG_W-1:0] PAT_0     = 7'h3F;
    localparam logic [SEG_W-1:0] PAT_1     = 7'h06;
    localparam logic [SEG_W-1:0] PAT_2     = 7'h5B;
    localparam logic [SEG_W-1:0] PAT_3     = 7'h4F;
    localparam logic [SEG_W-1:0] PAT_4     = 7'h66;
    localparam logic [SEG_W-1:0] PAT_5     = 7'h6D;
    localparam logic [SEG_W-1:0] PAT_6     = 7'h7D;
    localparam logic [SEG_W-1:0] PAT_7     = 7'h07;
    localparam logic [SEG_W-1:0] PAT_8     = 7'h7F;
    localparam logic [SEG_W-1:0] PAT_9     = 7'h6F;
    localparam logic [SEG_W-1:0] PAT_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Digit value to active-high segment pattern (driver side helper).
    function automatic logic [SEG_W-1:0] digit_pattern(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] p;
        case (d)
            4'd0:    p = PAT_0;
            4'd1:    p = PAT_1;
            4'd2:    p = PAT_2;
            4'd3:    p = PAT_3;
            4'd4:    p = PAT_4;
            4'd5:    p = PAT_5;
            4'd6:    p = PAT_6;
            4'd7:    p = PAT_7;
            4'd8:    p = PAT_8;
            4'd9:    p = PAT_9;
            default: p = PAT_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational pattern-to-BCD decoder; all-off is blank, unlisted patterns are invalid.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pat,
    output logic [BCD_W-1:0] bcd,
    output logic             blank,
    output logic             invalid
);

    // Map one active-high pattern to its digit value.
    always_comb begin
        bcd     = '0;
        blank   = 1'b0;
        invalid = 1'b0;
        case (pat)
            PAT_0:     bcd = 4'd0;
            PAT_1:     bcd = 4'd1;
            PAT_2:     bcd = 4'd2;
            PAT_3:     bcd = 4'd3;
            PAT_4:     bcd = 4'd4;
            PAT_5:     bcd = 4'd5;
            PAT_6:     bcd = 4'd6;
            PAT_7:     bcd = 4'd7;
            PAT_8:     bcd = 4'd8;
            PAT_9:     bcd = 4'd9;
            PAT_BLANK: blank = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: samples a multiplexed active-low 7-segment display and rebuilds the BCD frame.
// Optional: define SEG7_ERRCNT_EN to add the saturating err_cnt output.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  valid,
    output logic                  err
`ifdef SEG7_ERRCNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int unsigned SAMP_W   = DIGITS + SEG_W;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned ERRCNT_W = 8;

    logic [SAMP_W-1:0]   sync1, sync2, prev;
    logic [DIGITS-1:0]   dig_act;
    logic [SEG_W-1:0]    pat;
    logic                onehot;
    logic                changed;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic                accept;
    logic                restart;

    logic [BCD_W-1:0]    dec_bcd;
    logic                dec_blank;
    logic                dec_invalid;

    logic [4*DIGITS-1:0] shadow, shadow_n;
    logic [DIGITS-1:0]   sblank, sblank_n;
    logic [DIGITS-1:0]   mask, mask_n;
    logic                err_n;

    // Two-flop synchronizer on {dig_n, seg_n}, plus the previous sample for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {dig_n, seg_n};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign dig_act = ~sync2[SEG_W +: DIGITS];
    assign pat     = ~sync2[SEG_W-1:0];
    assign onehot  = (dig_act != '0) && ((dig_act & (dig_act - DIGITS'(1))) == '0);
    assign changed = (sync2 != prev);

    seg7_decode u_decode (
        .pat     (pat),
        .bcd     (dec_bcd),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    // FSM state and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next state: a fresh sample counts as sample one; the STABLE-th identical sample accepts once.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        accept  = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (onehot) restart = 1'b1;
            end
            SETTLE: begin
                if (!onehot) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (changed) begin
                    restart = 1'b1;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(STABLE)) begin
                    accept  = 1'b1;
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!onehot) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (changed) begin
                    restart = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // With STABLE of one the first sample already qualifies, so skip the settle dwell.
        if (restart) begin
            if (STABLE == 1) begin
                accept  = 1'b1;
                state_n = HOLD;
                cnt_n   = '0;
            end else begin
                state_n = SETTLE;
                cnt_n   = CNT_W'(1);
            end
        end
    end

    // Shadow/mask update: valid accepts write digit k; a full mask is consumed on the next edge.
    always_comb begin
        shadow_n = shadow;
        sblank_n = sblank;
        mask_n   = (&mask) ? '0 : mask;
        err_n    = accept && dec_invalid;
        if (accept && !dec_invalid) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                if (dig_act[k]) begin
                    shadow_n[4*k +: 4] = dec_bcd;
                    sblank_n[k]        = dec_blank;
                    mask_n[k]          = 1'b1;
                end
            end
        end
    end

    // Frame registers and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            sblank <= '0;
            mask   <= '0;
            bcd    <= '0;
            blank  <= '1;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else begin
            shadow <= shadow_n;
            sblank <= sblank_n;
            mask   <= mask_n;
            err    <= err_n;
            valid  <= &mask;
            if (&mask) begin
                bcd   <= shadow;
                blank <= sblank;
            end
        end
    end

`ifdef SEG7_ERRCNT_EN
    // Saturating error counter, stepped together with the err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_n && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end
`endif

endmodule
